// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully-connected layer engine.
package fc_pkg;

  // Width used when saturating; must be at least the accumulator width.
  localparam int SAT_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    BIAS,
    MAC,
    DRAIN,
    EMIT,
    DONE
  } fc_state_t;

  // Number of LANES-wide chunks needed to cover in_len activations.
  function automatic int fc_chunks(input int in_len, input int lanes);
    return (in_len + lanes - 1) / lanes;
  endfunction

  // Address width for a memory of the given depth (at least one bit).
  function automatic int fc_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Clamp a signed value into the signed range of 'width' bits.
  function automatic logic signed [SAT_W-1:0] sat_signed(
    input logic signed [SAT_W-1:0] value,
    input int                      width
  );
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    max_v = (SAT_W'(1) <<< (width - 1)) - SAT_W'(1);
    min_v = ~max_v;
    if (value > max_v) begin
      return max_v;
    end
    if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/fc_lane_dot.sv
// Combinational LANES-wide signed dot product. Masked lanes contribute zero
// regardless of the data presented on them.
module fc_lane_dot
  import fc_pkg::*;
#(
  parameter int LANES = 8,
  parameter int ACT_W = 32,
  parameter int W_W   = 8,
  parameter int SUM_W = ACT_W + W_W + $clog2(LANES) + 1
) (
  input  logic [LANES*ACT_W-1:0]  act,
  input  logic [LANES*W_W-1:0]    wgt,
  input  logic [LANES-1:0]        lane_valid,
  output logic signed [SUM_W-1:0] sum
);

  localparam int PROD_W = ACT_W + W_W;

  logic signed [PROD_W-1:0] prod [LANES];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] w_ext;

    // Sign-extend both operands so the truncated product is the exact product.
    assign a_ext = {{W_W{act[gi*ACT_W+ACT_W-1]}}, act[gi*ACT_W +: ACT_W]};
    assign w_ext = {{ACT_W{wgt[gi*W_W+W_W-1]}}, wgt[gi*W_W +: W_W]};
    assign prod[gi] = lane_valid[gi] ? (a_ext * w_ext) : {PROD_W{1'b0}};
  end

  // Sum the lane products at a width that cannot overflow.
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + {{(SUM_W-PROD_W){prod[i][PROD_W-1]}}, prod[i]};
    end
  end

endmodule

// File: rtl/fc_layer.sv
// Fully-connected layer engine: per neuron, bias + dot(acts, weights),
// optional ReLU, saturation, then one result on a valid/ready stream.
module fc_layer
  import fc_pkg::*;
#(
  parameter int IN_LEN  = 1568,
  parameter int OUT_LEN = 128,
  parameter int LANES   = 8,
  parameter int ACT_W   = 32,
  parameter int W_W     = 8,
  parameter int ACC_W   = 48,
  parameter int OUT_W   = 32,
  parameter int RELU    = 1
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   start,
  output logic                                                   busy,
  output logic                                                   done,
  output logic [fc_addr_w(fc_chunks(IN_LEN, LANES))-1:0]         act_rd_addr,
  input  logic [LANES*ACT_W-1:0]                                 act_rd_data,
  output logic [fc_addr_w(OUT_LEN*fc_chunks(IN_LEN, LANES))-1:0] w_rd_addr,
  input  logic [LANES*W_W-1:0]                                   w_rd_data,
  output logic [fc_addr_w(OUT_LEN)-1:0]                          bias_rd_addr,
  input  logic [ACC_W-1:0]                                       bias_rd_data,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic [OUT_W-1:0]                                       out_data,
  output logic [fc_addr_w(OUT_LEN)-1:0]                          out_idx
);

  localparam int CHUNKS = fc_chunks(IN_LEN, LANES);
  localparam int CA_W   = fc_addr_w(CHUNKS);
  localparam int NA_W   = fc_addr_w(OUT_LEN);
  localparam int SUM_W  = ACT_W + W_W + $clog2(LANES) + 1;

  fc_state_t               state_reg;
  logic [NA_W-1:0]         neuron_reg;
  logic [CA_W-1:0]         dchunk_reg;   // chunk whose data is on the RAM outputs
  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] psum_reg;     // registered lane sum awaiting accumulation

  logic [LANES-1:0]        lane_valid;
  logic signed [SUM_W-1:0] lane_sum;
  logic signed [ACC_W-1:0] lane_sum_ext;
  logic signed [ACC_W-1:0] acc_final;
  logic signed [ACC_W-1:0] relu_val;
  logic [OUT_W-1:0]        out_next;

  // Lanes beyond the last activation are masked off in the tail chunk.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_mask
    assign lane_valid[gi] = (32'(dchunk_reg) * 32'(LANES) + 32'(gi)) < 32'(IN_LEN);
  end

  fc_lane_dot #(
    .LANES (LANES),
    .ACT_W (ACT_W),
    .W_W   (W_W),
    .SUM_W (SUM_W)
  ) u_dot (
    .act        (act_rd_data),
    .wgt        (w_rd_data),
    .lane_valid (lane_valid),
    .sum        (lane_sum)
  );

  assign lane_sum_ext = ACC_W'(lane_sum);

  // Final accumulation, ReLU and saturation into the output width.
  always_comb begin
    acc_final = acc_reg + psum_reg;
    relu_val  = acc_final;
    if ((RELU != 0) && (acc_final < 0)) begin
      relu_val = '0;
    end
    out_next = OUT_W'(sat_signed(SAT_W'(relu_val), OUT_W));
  end

  // Control FSM, address generation, accumulator and output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      neuron_reg   <= '0;
      dchunk_reg   <= '0;
      acc_reg      <= '0;
      psum_reg     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      act_rd_addr  <= '0;
      w_rd_addr    <= '0;
      bias_rd_addr <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_idx      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            neuron_reg   <= '0;
            bias_rd_addr <= '0;
            act_rd_addr  <= '0;
            w_rd_addr    <= '0;
            busy         <= 1'b1;
            state_reg    <= BIAS;
          end
        end
        BIAS: begin
          // Chunk 0 is being read now; issue chunk 1 next.
          dchunk_reg <= '0;
          if (act_rd_addr != CA_W'(CHUNKS - 1)) begin
            act_rd_addr <= act_rd_addr + 1'b1;
            w_rd_addr   <= w_rd_addr + 1'b1;
          end
          state_reg <= MAC;
        end
        MAC: begin
          if (dchunk_reg == '0) begin
            acc_reg <= signed'(bias_rd_data);
          end else begin
            acc_reg <= acc_reg + psum_reg;
          end
          psum_reg   <= lane_sum_ext;
          dchunk_reg <= dchunk_reg + 1'b1;
          if (act_rd_addr != CA_W'(CHUNKS - 1)) begin
            act_rd_addr <= act_rd_addr + 1'b1;
            w_rd_addr   <= w_rd_addr + 1'b1;
          end
          if (dchunk_reg == CA_W'(CHUNKS - 1)) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          acc_reg   <= acc_final;
          out_data  <= out_next;
          out_idx   <= neuron_reg;
          out_valid <= 1'b1;
          state_reg <= EMIT;
        end
        EMIT: begin
          // Addresses and the result are frozen until the consumer accepts.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (neuron_reg == NA_W'(OUT_LEN - 1)) begin
              done      <= 1'b1;
              busy      <= 1'b0;
              state_reg <= DONE;
            end else begin
              neuron_reg   <= neuron_reg + 1'b1;
              bias_rd_addr <= neuron_reg + 1'b1;
              act_rd_addr  <= '0;
              // Weight rows are contiguous, so the next row starts right after.
              w_rd_addr    <= w_rd_addr + 1'b1;
              state_reg    <= BIAS;
            end
          end
        end
        DONE: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer.sv
// Directed testbench for fc_layer: a ReLU and a linear instance run in lockstep
// on shared RAM contents (IN_LEN=10, LANES=4 -> 3 chunks with a 2-lane tail).
module tb_fc_layer;

  localparam int IN_LEN  = 10;
  localparam int OUT_LEN = 2;
  localparam int LANES   = 4;
  localparam int ACT_W   = 32;
  localparam int W_W     = 8;
  localparam int ACC_W   = 48;
  localparam int OUT_W   = 16;
  localparam int CHUNKS  = 3;
  localparam int CA_W    = 2;
  localparam int WA_W    = 3;
  localparam int NA_W    = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic out_ready = 1'b0;

  logic              busy, done, out_valid;
  logic [CA_W-1:0]   act_addr;
  logic [WA_W-1:0]   w_addr;
  logic [NA_W-1:0]   b_addr, out_idx;
  logic [OUT_W-1:0]  out_data;
  logic [LANES*ACT_W-1:0] act_q, l_act_q;
  logic [LANES*W_W-1:0]   w_q, l_w_q;
  logic [ACC_W-1:0]       b_q, l_b_q;

  logic              lin_busy, lin_done, lin_valid;
  logic [CA_W-1:0]   lin_act_addr;
  logic [WA_W-1:0]   lin_w_addr;
  logic [NA_W-1:0]   lin_b_addr, lin_idx;
  logic [OUT_W-1:0]  lin_data;

  logic [LANES*ACT_W-1:0] act_mem [CHUNKS];
  logic [LANES*W_W-1:0]   w_mem   [OUT_LEN*CHUNKS];
  logic [ACC_W-1:0]       bias_mem[OUT_LEN];

  int total = 0;
  int bad = 0;

  logic [OUT_W-1:0] res_d [2];
  logic [OUT_W-1:0] res_l [2];
  logic [NA_W-1:0]  res_i [2];
  int n_got, first_valid, done_cyc, lock_bad;
  logic busy_c1;

  always #5 clk = ~clk;

  // Synchronous RAM models, one read port per instance, 1-cycle latency.
  always @(posedge clk) begin
    act_q   <= act_mem[act_addr];
    w_q     <= w_mem[w_addr];
    b_q     <= bias_mem[b_addr];
    l_act_q <= act_mem[lin_act_addr];
    l_w_q   <= w_mem[lin_w_addr];
    l_b_q   <= bias_mem[lin_b_addr];
  end

  fc_layer #(
    .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .LANES(LANES), .ACT_W(ACT_W),
    .W_W(W_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .RELU(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .act_rd_addr(act_addr), .act_rd_data(act_q),
    .w_rd_addr(w_addr), .w_rd_data(w_q),
    .bias_rd_addr(b_addr), .bias_rd_data(b_q),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx)
  );

  fc_layer #(
    .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .LANES(LANES), .ACT_W(ACT_W),
    .W_W(W_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .RELU(0)
  ) dut_lin (
    .clk(clk), .reset(reset), .start(start), .busy(lin_busy), .done(lin_done),
    .act_rd_addr(lin_act_addr), .act_rd_data(l_act_q),
    .w_rd_addr(lin_w_addr), .w_rd_data(l_w_q),
    .bias_rd_addr(lin_b_addr), .bias_rd_data(l_b_q),
    .out_valid(lin_valid), .out_ready(out_ready),
    .out_data(lin_data), .out_idx(lin_idx)
  );

  // Fill RAMs; lanes at global index >= IN_LEN hold 0x7F garbage.
  task automatic load_data(input int kind);
    logic [ACT_W-1:0] a;
    logic [W_W-1:0]   w0, w1;
    int b0, b1;
    for (int i = 0; i < CHUNKS*LANES; i++) begin
      case (kind)
        0:       begin a = 1;            w0 = 2;              w1 = 2; end
        1:       begin a = 0;            w0 = 5;              w1 = W_W'(-3); end
        2:       begin a = 32767;        w0 = 127;            w1 = W_W'(-128); end
        default: begin a = ACT_W'(i+1);  w0 = W_W'((i%3)-1);  w1 = 3; end
      endcase
      if (i >= IN_LEN) begin
        a = 32'h7F; w0 = 8'h7F; w1 = 8'h7F;
      end
      act_mem[i/LANES][(i%LANES)*ACT_W +: ACT_W] = a;
      w_mem[i/LANES][(i%LANES)*W_W +: W_W] = w0;
      w_mem[CHUNKS + i/LANES][(i%LANES)*W_W +: W_W] = w1;
    end
    case (kind)
      0:       begin b0 = 0;     b1 = -5;   end
      1:       begin b0 = -1000; b1 = 7;    end
      2:       begin b0 = 0;     b1 = 0;    end
      default: begin b0 = 100;   b1 = -200; end
    endcase
    bias_mem[0] = ACC_W'(b0);
    bias_mem[1] = ACC_W'(b1);
  endtask

  // One full pass with out_ready high; start held for hold_start cycles.
  task automatic run_pass(input int hold_start);
    int cyc;
    n_got = 0; first_valid = -1; done_cyc = -1; lock_bad = 0; busy_c1 = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    while (done_cyc < 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc >= hold_start) start = 1'b0;
      if (cyc == 1) busy_c1 = busy;
      if (out_valid !== lin_valid || done !== lin_done) lock_bad++;
      if (done === 1'b1) done_cyc = cyc;
      if (out_valid === 1'b1) begin
        if (first_valid < 0) first_valid = cyc;
        if (n_got < 2) begin
          res_d[n_got] = out_data;
          res_l[n_got] = lin_data;
          res_i[n_got] = out_idx;
        end
        $display("cycle %0d: out idx=%0d relu=%0d linear=%0d", cyc, out_idx,
                 $signed(out_data), $signed(lin_data));
        n_got++;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_data: got %0d want 0", out_data); end
    total++; if ({act_addr, w_addr, b_addr, out_idx} !== '0) begin bad++; $display("FAIL reset_addr: got %h want 0", {act_addr, w_addr, b_addr, out_idx}); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic;
    load_data(0);
    run_pass(3);  // start kept high into BIAS/MAC must be ignored
    total++; if (n_got != 2) begin bad++; $display("FAIL basic_count: got %0d want 2", n_got); end
    total++; if (busy_c1 !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy_c1); end
    total++; if (first_valid != CHUNKS+3) begin bad++; $display("FAIL basic_first_valid: got %0d want %0d", first_valid, CHUNKS+3); end
    total++; if (done_cyc != 2*(CHUNKS+3)+1) begin bad++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, 2*(CHUNKS+3)+1); end
    total++; if (res_i[0] !== 1'b0 || res_i[1] !== 1'b1) begin bad++; $display("FAIL basic_idx: got %0d,%0d want 0,1", res_i[0], res_i[1]); end
    total++; if (res_d[0] !== OUT_W'(20)) begin bad++; $display("FAIL basic_n0: got %0d want 20", $signed(res_d[0])); end
    total++; if (res_d[1] !== OUT_W'(15)) begin bad++; $display("FAIL basic_n1: got %0d want 15", $signed(res_d[1])); end
    total++; if (res_l[1] !== OUT_W'(15)) begin bad++; $display("FAIL basic_lin_n1: got %0d want 15", $signed(res_l[1])); end
    total++; if (lock_bad != 0) begin bad++; $display("FAIL basic_lockstep: got %0d want 0", lock_bad); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL basic_after_done: got busy=%b done=%b want 0,0", busy, done); end
  endtask

  task automatic test_relu;
    load_data(1);
    run_pass(1);
    total++; if (res_d[0] !== OUT_W'(0)) begin bad++; $display("FAIL relu_n0: got %0d want 0", $signed(res_d[0])); end
    total++; if (res_l[0] !== OUT_W'(-1000)) begin bad++; $display("FAIL linear_n0: got %0d want -1000", $signed(res_l[0])); end
    total++; if (res_d[1] !== OUT_W'(7)) begin bad++; $display("FAIL relu_n1: got %0d want 7", $signed(res_d[1])); end
  endtask

  task automatic test_saturation;
    load_data(2);
    run_pass(1);
    total++; if (res_d[0] !== OUT_W'(32767)) begin bad++; $display("FAIL sat_pos: got %0d want 32767", $signed(res_d[0])); end
    total++; if (res_l[1] !== OUT_W'(-32768)) begin bad++; $display("FAIL sat_neg: got %0d want -32768", $signed(res_l[1])); end
    total++; if (res_d[1] !== OUT_W'(0)) begin bad++; $display("FAIL sat_neg_relu: got %0d want 0", $signed(res_d[1])); end
  endtask

  task automatic test_mixed;
    load_data(3);
    run_pass(1);
    total++; if (res_d[0] !== OUT_W'(96)) begin bad++; $display("FAIL mixed_n0: got %0d want 96", $signed(res_d[0])); end
    total++; if (res_l[1] !== OUT_W'(-35)) begin bad++; $display("FAIL mixed_lin_n1: got %0d want -35", $signed(res_l[1])); end
    total++; if (res_d[1] !== OUT_W'(0)) begin bad++; $display("FAIL mixed_relu_n1: got %0d want 0", $signed(res_d[1])); end
  endtask

  task automatic test_backpressure;
    int waited;
    load_data(0);
    out_ready = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 50) begin @(negedge clk); waited++; end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_timeout: got %b want 1", out_valid); end
    for (int s = 0; s < 5; s++) begin
      total++; if (out_valid !== 1'b1 || out_data !== OUT_W'(20) || out_idx !== 1'b0) begin bad++; $display("FAIL bp_hold_%0d: got v=%b d=%0d i=%0d want 1,20,0", s, out_valid, $signed(out_data), out_idx); end
      total++; if (act_addr !== 2'd2 || w_addr !== 3'd2 || b_addr !== 1'b0) begin bad++; $display("FAIL bp_addr_%0d: got a=%0d w=%0d b=%0d want 2,2,0", s, act_addr, w_addr, b_addr); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL bp_done_%0d: got %b want 0", s, done); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    $display("bp: neuron 0 accepted after stall, data=%0d", $signed(out_data));
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || b_addr !== 1'b1 || act_addr !== 2'd0 || w_addr !== 3'd3) begin bad++; $display("FAIL bp_next_bias: got v=%b b=%0d a=%0d w=%0d want 0,1,0,3", out_valid, b_addr, act_addr, w_addr); end
    waited = 0;
    while (out_valid !== 1'b1 && waited < 50) begin @(negedge clk); waited++; end
    total++; if (out_data !== OUT_W'(15) || out_idx !== 1'b1 || w_addr !== 3'd5) begin bad++; $display("FAIL bp_n1: got d=%0d i=%0d w=%0d want 15,1,5", $signed(out_data), out_idx, w_addr); end
    waited = 0;
    while (done !== 1'b1 && waited < 50) begin @(negedge clk); waited++; end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL bp_done: got %b want 1", done); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int waited;
    int done_seen;
    load_data(0);
    out_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 50) begin @(negedge clk); waited++; end
    @(negedge clk);  // BIAS of neuron 1
    @(negedge clk);  // first MAC cycle of neuron 1
    total++; if (busy !== 1'b1 || b_addr !== 1'b1 || out_data !== OUT_W'(20)) begin bad++; $display("FAIL rst_pre: got busy=%b b=%0d d=%0d want 1,1,20", busy, b_addr, $signed(out_data)); end
    reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_ctrl: got busy=%b done=%b v=%b want 0,0,0", busy, done, out_valid); end
    total++; if (out_data !== '0 || out_idx !== '0) begin bad++; $display("FAIL rst_mid_out: got d=%0d i=%0d want 0,0", out_data, out_idx); end
    total++; if (act_addr !== '0 || w_addr !== '0 || b_addr !== '0) begin bad++; $display("FAIL rst_mid_addr: got a=%0d w=%0d b=%0d want 0,0,0", act_addr, w_addr, b_addr); end
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1 || out_valid === 1'b1) done_seen++;
    end
    total++; if (done_seen != 0) begin bad++; $display("FAIL rst_quiet: got %0d active cycles want 0", done_seen); end
    load_data(3);
    run_pass(1);
    total++; if (res_d[0] !== OUT_W'(96) || res_l[1] !== OUT_W'(-35)) begin bad++; $display("FAIL rst_rerun: got %0d,%0d want 96,-35", $signed(res_d[0]), $signed(res_l[1])); end
    total++; if (done_cyc != 2*(CHUNKS+3)+1) begin bad++; $display("FAIL rst_rerun_done: got %0d want %0d", done_cyc, 2*(CHUNKS+3)+1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_saturation();
    test_mixed();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
